mesh_term_arbiter: RTL and testbench
====================================

# mesh_term_arbiter

Round-robin injection scheduler that shares one mesh terminal input port of `mesh_gnrtr` among `NREQ` local requester FIFOs. It pops one packet at a time from the granted requester and checks its destination field. It drops packets with out-of-range destinations and presents valid ones to the router through the terminal's `pndng_i_in`/`data_out_i_in`/`popin` handshake. One instance sits in front of each terminal that has multiple traffic sources.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `PAKG_SIZE`, 32: packet width in bits.
- `ROWS`, 4: mesh rows.
- `COLUMNS`, 4: mesh columns.
- `BDCST`, 8'hFF: broadcast tag value in packet bits [PAKG_SIZE-1:PAKG_SIZE-8].
- `CNT_W`, 16: width of statistics counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_pndng`  in  NREQ  requester i has a packet at its FIFO head.
- `req_data`  in  NREQ*PAKG_SIZE  head packet of requester i, in slice [i*PAKG_SIZE +: PAKG_SIZE].
- `req_pop`  out  NREQ  one-hot, single-cycle pop to the granted requester.
- `pndng`  out  1  packet available to router (drives `pndng_i_in`).
- `data_out`  out  PAKG_SIZE  held packet (drives `data_out_i_in`).
- `popin`  in  1  router consumed the held packet.
- `grant_id`  out  $clog2(NREQ)  index of the requester whose packet is held or last granted.
- `fwd_cnt`  out  CNT_W  packets delivered to the router.
- `drop_cnt`  out  CNT_W  packets discarded for invalid destination.

## Operation
- Packet fields:
  - dest row = [PAKG_SIZE-9:PAKG_SIZE-12].
  - dest col = [PAKG_SIZE-13:PAKG_SIZE-16].
  - broadcast when [PAKG_SIZE-1:PAKG_SIZE-8] == BDCST.
- Valid destination: broadcast, or (row ≤ ROWS+1 and col ≤ COLUMNS+1).
- Round-robin pointer `ptr` (reset 0). The winner is the first i with `req_pndng[i]=1`, searching from `ptr` upward with wrap at NREQ.
- States:
  - IDLE: if any `req_pndng`:
    - assert `req_pop[winner]` combinationally this cycle and capture `req_data[winner]` into the hold register; `grant_id <= winner`.
    - if valid: go to HOLD.
    - if invalid: stay in IDLE, `drop_cnt`+1, `ptr <= winner+1` (mod NREQ).
    - if no `req_pndng`: `req_pop`=0, stay in IDLE.
  - HOLD: `pndng`=1, `data_out`=hold register, `req_pop`=0.
    - On `popin`=1: `fwd_cnt`+1, `ptr <= grant_id+1` (mod NREQ), go to IDLE.
- `req_pop` is asserted only in IDLE, at most one bit at a time, and never in HOLD.
- `popin` in IDLE is ignored with no counter change.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- `req_pndng` deasserting while in HOLD has no effect; the packet is already captured.
- Reset in any state, including HOLD:
  - the held packet is discarded and the FSM goes to IDLE;
  - `ptr`=0 and counters = 0;
  - a packet popped from a requester before reset is lost; this is accepted.

## Timing
- Reset values: `req_pop`=0, `pndng`=0, `data_out`=0, `grant_id`=0, `fwd_cnt`=0, `drop_cnt`=0.
- Grant latency: `req_pndng` high in IDLE cycle t gives `req_pop` in cycle t, and `pndng`=1 from cycle t+1.
- Release: `popin` sampled high in cycle u gives `pndng`=0 in cycle u+1. The next grant can occur in cycle u+1, so a packet needs at least 2 cycles.
- Drop: an invalid packet consumes one IDLE cycle, and the next grant can occur in cycle t+1.
- `data_out` holds stable for the whole time `pndng`=1. After `popin` it keeps its last value; only `pndng` indicates validity.
- `grant_id` updates on the clock edge that ends the grant cycle.
- Counters update on the clock edge that ends the event cycle.

## Test plan
- Single requester: req 2 pends packet row=1,col=3 at cycle 10; `popin` at 12. Required:
  - `req_pop`=4'b0100 at 10;
  - `pndng`=1 at 11–12, 0 at 13;
  - `fwd_cnt`=1, `grant_id`=2.
- Fairness: all 4 requesters continuously pending and `popin` pulsed each HOLD cycle. Required:
  - grant order 0,1,2,3,0,1;
  - `fwd_cnt`=6 after 6 handshakes;
  - `req_pop` never has two bits high.
- Drop: req 1 head has row=ROWS+2 (6), followed by a valid packet. Required:
  - `drop_cnt`=1 with `pndng` staying 0;
  - next cycle req 1 is granted again, `pndng`=1 with the valid packet.
- Broadcast: top byte 8'hFF with row=15. Required: forwarded, not dropped; `fwd_cnt`+1.
- Backpressure: `popin` withheld for 20 cycles. Required:
  - `pndng` and `data_out` stable for the whole period;
  - no `req_pop` while other requesters pend;
  - release occurs exactly 1 cycle after `popin`.
- Reset in HOLD: `reset` asserted for 1 cycle while `pndng`=1. Required:
  - next cycle `pndng`=0, counters 0, `grant_id`=0;
  - after reset, arbitration restarts at requester 0.

Source files
------------

// File: rtl/mesh_term_arbiter.sv
// Round-robin injection scheduler for one mesh terminal port.
// Pops one packet per grant, drops bad destinations, holds good ones.
module mesh_term_arbiter #(
  parameter int          NREQ      = 4,
  parameter int          PAKG_SIZE = 32,
  parameter int          ROWS      = 4,
  parameter int          COLUMNS   = 4,
  parameter logic [7:0]  BDCST     = 8'hFF,
  parameter int          CNT_W     = 16,
  localparam int         IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_pndng,
  input  logic [NREQ*PAKG_SIZE-1:0] req_data,
  output logic [NREQ-1:0]           req_pop,
  output logic                      pndng,
  output logic [PAKG_SIZE-1:0]      data_out,
  input  logic                      popin,
  output logic [IW-1:0]             grant_id,
  output logic [CNT_W-1:0]          fwd_cnt,
  output logic [CNT_W-1:0]          drop_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [4:0] ROW_MAX = 5'(ROWS + 1);
  localparam logic [4:0] COL_MAX = 5'(COLUMNS + 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        grant_q;
  logic [PAKG_SIZE-1:0] hold_q;
  logic [CNT_W-1:0]     fwd_q, drop_q;

  logic [IW-1:0]        win;
  logic                 found;
  logic [IW:0]          sum;
  logic [PAKG_SIZE-1:0] win_pkt;
  logic [7:0]           tag;
  logic [3:0]           row, col;
  logic                 pkt_ok;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] v);
    if (v == IW'(NREQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  // first pending requester at or after ptr, wrapping at NREQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!found && req_pndng[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  assign win_pkt = req_data[int'(win)*PAKG_SIZE +: PAKG_SIZE];
  assign tag     = win_pkt[PAKG_SIZE-1  -: 8];
  assign row     = win_pkt[PAKG_SIZE-9  -: 4];
  assign col     = win_pkt[PAKG_SIZE-13 -: 4];
  assign pkt_ok  = (tag == BDCST) ||
                   (({1'b0, row} <= ROW_MAX) && ({1'b0, col} <= COL_MAX));

  always_comb begin
    state_d = state_q;
    req_pop = '0;
    unique case (state_q)
      IDLE: begin
        if (found && !reset) begin
          req_pop = NREQ'(1) << win;
          if (pkt_ok) state_d = HOLD;
        end
      end
      HOLD: begin
        if (popin) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      hold_q  <= '0;
      fwd_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            hold_q  <= win_pkt;
            grant_q <= win;
            if (!pkt_ok) begin
              ptr_q <= nxt(win);
              if (drop_q != '1) drop_q <= drop_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (popin) begin
            ptr_q <= nxt(grant_q);
            if (fwd_q != '1) fwd_q <= fwd_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign pndng    = (state_q == HOLD);
  assign data_out = hold_q;
  assign grant_id = grant_q;
  assign fwd_cnt  = fwd_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mesh_term_arbiter.sv
// Directed bench for mesh_term_arbiter.
// Inputs change at negedge; outputs sampled #1 later.
module tb_mesh_term_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_pndng;
  logic [127:0] req_data;
  logic [3:0]   req_pop;
  logic         pndng;
  logic [31:0]  data_out;
  logic         popin;
  logic [1:0]   grant_id;
  logic [15:0]  fwd_cnt;
  logic [15:0]  drop_cnt;

  int passed = 0;
  int total  = 0;

  logic [31:0] pk [4];
  logic [31:0] p;
  logic [31:0] q;

  mesh_term_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_pndng (req_pndng),
    .req_data  (req_data),
    .req_pop   (req_pop),
    .pndng     (pndng),
    .data_out  (data_out),
    .popin     (popin),
    .grant_id  (grant_id),
    .fwd_cnt   (fwd_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] r, input logic [3:0] c,
                                     input logic [7:0] t, input logic [15:0] pay);
    return {t, r, c, pay};
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    req_pndng = '0;
    popin = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (req_pop !== 4'b0) $display("FAIL rst_pop got %b want 0", req_pop); else passed++;
    total++; if (pndng !== 1'b0) $display("FAIL rst_pndng got %b want 0", pndng); else passed++;
    total++; if (data_out !== 32'h0) $display("FAIL rst_data got %h want 0", data_out); else passed++;
    total++; if (grant_id !== 2'd0) $display("FAIL rst_gid got %0d want 0", grant_id); else passed++;
    total++; if (fwd_cnt !== 16'd0) $display("FAIL rst_fwd got %0d want 0", fwd_cnt); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop got %0d want 0", drop_cnt); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    p = mk(4'd1, 4'd3, 8'h00, 16'h1234);
    @(negedge clk);
    req_data[2*32 +: 32] = p;
    req_pndng = 4'b0100;
    #1;
    total++; if (req_pop !== 4'b0100) $display("FAIL single_pop got %b want 0100", req_pop); else passed++;
    @(negedge clk);
    req_pndng = 4'b0000;
    #1;
    total++; if (pndng !== 1'b1) $display("FAIL single_pndng1 got %b want 1", pndng); else passed++;
    total++; if (data_out !== p) $display("FAIL single_data got %h want %h", data_out, p); else passed++;
    @(negedge clk);
    popin = 1'b1;
    #1;
    total++; if (pndng !== 1'b1) $display("FAIL single_pndng2 got %b want 1", pndng); else passed++;
    @(negedge clk);
    popin = 1'b0;
    #1;
    total++; if (pndng !== 1'b0) $display("FAIL single_release got %b want 0", pndng); else passed++;
    total++; if (fwd_cnt !== 16'd1) $display("FAIL single_fwd got %0d want 1", fwd_cnt); else passed++;
    total++; if (grant_id !== 2'd2) $display("FAIL single_gid got %0d want 2", grant_id); else passed++;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_pop;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      pk[i] = mk(4'(i), 4'(i), 8'h00, 16'(16'hA000 + i));
      req_data[i*32 +: 32] = pk[i];
    end
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      req_pndng = 4'hF;
      popin = 1'b0;
      #1;
      exp_pop = 4'b0001 << (g % 4);
      total++; if (req_pop !== exp_pop) $display("FAIL fair_pop%0d got %b want %b", g, req_pop, exp_pop); else passed++;
      total++; if ($countones(req_pop) > 1) $display("FAIL fair_onehot%0d got %b want one-hot", g, req_pop); else passed++;
      @(negedge clk);
      popin = 1'b1;
      #1;
      total++; if (pndng !== 1'b1) $display("FAIL fair_pndng%0d got %b want 1", g, pndng); else passed++;
      total++; if (data_out !== pk[g%4]) $display("FAIL fair_data%0d got %h want %h", g, data_out, pk[g%4]); else passed++;
      total++; if (req_pop !== 4'b0) $display("FAIL fair_holdpop%0d got %b want 0", g, req_pop); else passed++;
    end
    @(negedge clk);
    popin = 1'b0;
    req_pndng = 4'b0;
    #1;
    total++; if (fwd_cnt !== 16'd6) $display("FAIL fair_fwd got %0d want 6", fwd_cnt); else passed++;
    total++; if (pndng !== 1'b0) $display("FAIL fair_idle got %b want 0", pndng); else passed++;
  endtask

  task automatic test_drop();
    p = mk(4'd6, 4'd0, 8'h00, 16'hDEAD);
    q = mk(4'd2, 4'd2, 8'h00, 16'hBEEF);
    @(negedge clk);
    req_data[1*32 +: 32] = p;
    req_pndng = 4'b0010;
    #1;
    total++; if (req_pop !== 4'b0010) $display("FAIL drop_pop1 got %b want 0010", req_pop); else passed++;
    @(negedge clk);
    req_data[1*32 +: 32] = q;
    #1;
    total++; if (pndng !== 1'b0) $display("FAIL drop_pndng got %b want 0", pndng); else passed++;
    total++; if (drop_cnt !== 16'd1) $display("FAIL drop_cnt got %0d want 1", drop_cnt); else passed++;
    total++; if (req_pop !== 4'b0010) $display("FAIL drop_regrant got %b want 0010", req_pop); else passed++;
    @(negedge clk);
    req_pndng = 4'b0;
    popin = 1'b1;
    #1;
    total++; if (pndng !== 1'b1) $display("FAIL drop_valid got %b want 1", pndng); else passed++;
    total++; if (data_out !== q) $display("FAIL drop_data got %h want %h", data_out, q); else passed++;
    @(negedge clk);
    popin = 1'b0;
    #1;
    total++; if (fwd_cnt !== 16'd7) $display("FAIL drop_fwd got %0d want 7", fwd_cnt); else passed++;
  endtask

  task automatic test_boundary();
    p = mk(4'd5, 4'd5, 8'h00, 16'h5555);
    q = mk(4'd5, 4'd6, 8'h00, 16'h6666);
    @(negedge clk);
    req_data[3*32 +: 32] = p;
    req_pndng = 4'b1000;
    #1;
    total++; if (req_pop !== 4'b1000) $display("FAIL bnd_pop1 got %b want 1000", req_pop); else passed++;
    @(negedge clk);
    req_data[3*32 +: 32] = q;
    popin = 1'b1;
    #1;
    total++; if (pndng !== 1'b1) $display("FAIL bnd_edge_ok got %b want 1", pndng); else passed++;
    total++; if (data_out !== p) $display("FAIL bnd_data got %h want %h", data_out, p); else passed++;
    @(negedge clk);
    popin = 1'b0;
    #1;
    total++; if (req_pop !== 4'b1000) $display("FAIL bnd_pop2 got %b want 1000", req_pop); else passed++;
    @(negedge clk);
    req_pndng = 4'b0;
    #1;
    total++; if (pndng !== 1'b0) $display("FAIL bnd_col_drop got %b want 0", pndng); else passed++;
    total++; if (drop_cnt !== 16'd2) $display("FAIL bnd_drop got %0d want 2", drop_cnt); else passed++;
    total++; if (fwd_cnt !== 16'd8) $display("FAIL bnd_fwd got %0d want 8", fwd_cnt); else passed++;
  endtask

  task automatic test_broadcast();
    p = mk(4'hF, 4'hF, 8'hFF, 16'hB0B0);
    @(negedge clk);
    req_data[0 +: 32] = p;
    req_pndng = 4'b0001;
    #1;
    total++; if (req_pop !== 4'b0001) $display("FAIL bc_pop got %b want 0001", req_pop); else passed++;
    @(negedge clk);
    req_pndng = 4'b0;
    popin = 1'b1;
    #1;
    total++; if (pndng !== 1'b1) $display("FAIL bc_pndng got %b want 1", pndng); else passed++;
    total++; if (data_out !== p) $display("FAIL bc_data got %h want %h", data_out, p); else passed++;
    @(negedge clk);
    popin = 1'b0;
    #1;
    total++; if (fwd_cnt !== 16'd9) $display("FAIL bc_fwd got %0d want 9", fwd_cnt); else passed++;
    total++; if (drop_cnt !== 16'd2) $display("FAIL bc_drop got %0d want 2", drop_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    pulse_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = pk[i];
    @(negedge clk);
    req_pndng = 4'hF;
    #1;
    total++; if (req_pop !== 4'b0001) $display("FAIL bp_pop got %b want 0001", req_pop); else passed++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      total++; if (pndng !== 1'b1) $display("FAIL bp_pndng%0d got %b want 1", c, pndng); else passed++;
      total++; if (data_out !== pk[0]) $display("FAIL bp_data%0d got %h want %h", c, data_out, pk[0]); else passed++;
      total++; if (req_pop !== 4'b0) $display("FAIL bp_nopop%0d got %b want 0", c, req_pop); else passed++;
    end
    @(negedge clk);
    popin = 1'b1;
    #1;
    total++; if (pndng !== 1'b1) $display("FAIL bp_last got %b want 1", pndng); else passed++;
    @(negedge clk);
    popin = 1'b0;
    #1;
    total++; if (pndng !== 1'b0) $display("FAIL bp_release got %b want 0", pndng); else passed++;
    total++; if (fwd_cnt !== 16'd1) $display("FAIL bp_fwd got %0d want 1", fwd_cnt); else passed++;
    total++; if (req_pop !== 4'b0010) $display("FAIL bp_next got %b want 0010", req_pop); else passed++;
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (pndng !== 1'b1) $display("FAIL rh_pre got %b want 1", pndng); else passed++;
    total++; if (grant_id !== 2'd1) $display("FAIL rh_gid_pre got %0d want 1", grant_id); else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (pndng !== 1'b0) $display("FAIL rh_pndng got %b want 0", pndng); else passed++;
    total++; if (fwd_cnt !== 16'd0) $display("FAIL rh_fwd got %0d want 0", fwd_cnt); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("FAIL rh_drop got %0d want 0", drop_cnt); else passed++;
    total++; if (grant_id !== 2'd0) $display("FAIL rh_gid got %0d want 0", grant_id); else passed++;
    total++; if (req_pop !== 4'b0001) $display("FAIL rh_restart got %b want 0001", req_pop); else passed++;
    @(negedge clk);
    req_pndng = 4'b0;
    popin = 1'b1;
    #1;
    total++; if (data_out !== pk[0]) $display("FAIL rh_data got %h want %h", data_out, pk[0]); else passed++;
    @(negedge clk);
    popin = 1'b0;
    #1;
    total++; if (fwd_cnt !== 16'd1) $display("FAIL rh_fwd2 got %0d want 1", fwd_cnt); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    req_pndng = '0;
    req_data = '0;
    popin = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_drop();
    test_boundary();
    test_broadcast();
    test_backpressure();
    test_reset_hold();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
